// File: rtl/programmable_frequency_divider_if.sv
// Divisor load channel for programmable_frequency_divider: divisor plus valid/ready.
interface programmable_frequency_divider_if #(
  parameter int DIVIDER_BITS = 8
);
  logic [DIVIDER_BITS-1:0] divisorIn;
  logic                    loadValid;
  logic                    loadReady;

  modport master (output divisorIn, output loadValid, input  loadReady);
  modport slave  (input  divisorIn, input  loadValid, output loadReady);
endinterface

// File: rtl/programmable_frequency_divider.sv
// Runtime-programmable clock divider with rise/fall strobes and glitch-free divisor updates.
// Optional FREQDIV_PERIOD_COUNT_EN adds a 16-bit count of generated periods.
module programmable_frequency_divider #(
  parameter int DIVIDER_BITS    = 8,
  parameter int DEFAULT_DIVIDER = 2
) (
  input  logic inputCLK,
  input  logic reset,
  input  logic enable,
  programmable_frequency_divider_if.slave ld,
  output logic outputCLK,
  output logic risePulse,
  output logic fallPulse,
  output logic running
`ifdef FREQDIV_PERIOD_COUNT_EN
  ,
  output logic [15:0] periodCount
`endif
);
  localparam int W = DIVIDER_BITS;
  localparam logic [W-1:0] ONE     = W'(1);
  localparam logic [W-1:0] TWO     = W'(2);
  localparam logic [W-1:0] DEF_DIV = W'(DEFAULT_DIVIDER);
  localparam logic [W:0]   ONE_X   = (W+1)'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [W-1:0] cnt, activeDiv, pendingDiv;
  logic         pendingValid;
  logic [W-1:0] loadDiv, cntInc;
  logic [W:0]   half;
  logic         hs, boundary;

  assign loadDiv      = (ld.divisorIn < TWO) ? TWO : ld.divisorIn;
  assign ld.loadReady = ~pendingValid;
  assign hs           = ld.loadValid & ~pendingValid;
  assign running      = (state == RUN);
  // high phase length: ceil(D/2), one bit wider so D=2^W-1 cannot overflow
  assign half         = ({1'b0, activeDiv} + ONE_X) >> 1;
  assign boundary     = (cnt == activeDiv - ONE);
  assign cntInc       = cnt + ONE;

  always_ff @(posedge inputCLK) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      activeDiv    <= DEF_DIV;
      pendingDiv   <= DEF_DIV;
      pendingValid <= 1'b0;
      outputCLK    <= 1'b0;
      risePulse    <= 1'b0;
      fallPulse    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // idle loads bypass the pending slot; a same-cycle start uses them
          if (hs) activeDiv <= loadDiv;
          cnt       <= '0;
          fallPulse <= 1'b0;
          if (enable) begin
            state     <= RUN;
            outputCLK <= 1'b1;
            risePulse <= 1'b1;
          end else begin
            outputCLK <= 1'b0;
            risePulse <= 1'b0;
          end
        end
        RUN: begin
          if (boundary) begin
            cnt          <= '0;
            fallPulse    <= 1'b0;
            if (pendingValid) activeDiv <= pendingDiv;
            // a load landing on the boundary waits for the next one
            pendingValid <= hs;
            if (hs) pendingDiv <= loadDiv;
            if (enable) begin
              outputCLK <= 1'b1;
              risePulse <= 1'b1;
            end else begin
              state     <= IDLE;
              outputCLK <= 1'b0;
              risePulse <= 1'b0;
            end
          end else begin
            cnt       <= cntInc;
            outputCLK <= ({1'b0, cntInc} < half);
            risePulse <= 1'b0;
            fallPulse <= ({1'b0, cntInc} == half);
            if (hs) begin
              pendingDiv   <= loadDiv;
              pendingValid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FREQDIV_PERIOD_COUNT_EN
  always_ff @(posedge inputCLK) begin
    if (reset)          periodCount <= '0;
    else if (risePulse) periodCount <= periodCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_programmable_frequency_divider.sv
// Bench: period-waveform reference model, directed test-plan scenarios, then random traffic.
module tb_programmable_frequency_divider;
  localparam int DB  = 8;
  localparam int DEF = 2;

  logic inputCLK = 1'b0;
  logic reset, enable;
  logic outputCLK, risePulse, fallPulse, running;
`ifdef FREQDIV_PERIOD_COUNT_EN
  logic [15:0] periodCount;
  int unsigned m_pc;
`endif

  programmable_frequency_divider_if #(.DIVIDER_BITS(DB)) ld();

  programmable_frequency_divider #(.DIVIDER_BITS(DB), .DEFAULT_DIVIDER(DEF)) dut (
    .inputCLK (inputCLK),
    .reset    (reset),
    .enable   (enable),
    .ld       (ld),
    .outputCLK(outputCLK),
    .risePulse(risePulse),
    .fallPulse(fallPulse),
    .running  (running)
`ifdef FREQDIV_PERIOD_COUNT_EN
    ,
    .periodCount(periodCount)
`endif
  );

  always #5 inputCLK = ~inputCLK;

  typedef struct {bit clk; bit rise; bit fall;} rec_t;

  // model: remaining samples of the current period, pre-built as a whole waveform
  rec_t wave[$];
  rec_t cur;
  bit   m_run;
  int   adiv, pend, cyc;
  int   total, bad;
  logic [31:0] hist_clk, hist_rise, hist_fall, hist_run;

  function automatic int clampd(int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic start_period(int d);
    int h;
    rec_t r;
    h = (d + 1) / 2;
    wave.delete();
    for (int i = 0; i < d; i++) begin
      r.clk  = (i < h);
      r.rise = (i == 0);
      r.fall = (i == h);
      wave.push_back(r);
    end
    cur   = wave.pop_front();
    m_run = 1'b1;
  endtask

  task automatic idle_out();
    cur.clk = 1'b0; cur.rise = 1'b0; cur.fall = 1'b0;
  endtask

  // advance model with the inputs currently driven, clock once, compare
  task automatic step();
    bit hs;
    int dd;
    logic [4:0] got, exp;
    hs = ld.loadValid && (pend < 0);
    dd = clampd(int'(ld.divisorIn));
    if (reset) begin
      m_run = 1'b0; wave.delete(); adiv = DEF; pend = -1; idle_out();
`ifdef FREQDIV_PERIOD_COUNT_EN
      m_pc = 0;
`endif
    end else begin
`ifdef FREQDIV_PERIOD_COUNT_EN
      if (cur.rise) m_pc = (m_pc + 1) % 65536;
`endif
      if (!m_run) begin
        if (hs) adiv = dd;
        if (enable) start_period(adiv); else idle_out();
      end else if (wave.size() > 0) begin
        cur = wave.pop_front();
        if (hs) pend = dd;
      end else begin
        if (pend >= 0) begin adiv = pend; pend = -1; end
        if (hs) pend = dd;
        if (enable) start_period(adiv);
        else begin m_run = 1'b0; idle_out(); end
      end
    end
    @(posedge inputCLK);
    #1;
    cyc++;
    hist_clk  = {hist_clk[30:0],  outputCLK};
    hist_rise = {hist_rise[30:0], risePulse};
    hist_fall = {hist_fall[30:0], fallPulse};
    hist_run  = {hist_run[30:0],  running};
    got = {outputCLK, risePulse, fallPulse, running, ld.loadReady};
    exp = {cur.clk, cur.rise, cur.fall, m_run, pend < 0};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL cyc%0d outs{clk,rise,fall,run,rdy} got=%b exp=%b", cyc, got, exp);
    end
`ifdef FREQDIV_PERIOD_COUNT_EN
    total++;
    if (periodCount !== 16'(m_pc)) begin
      bad++;
      $display("FAIL cyc%0d periodCount got=%0d exp=%0d", cyc, periodCount, m_pc);
    end
`endif
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(int d);
    ld.loadValid = 1'b1; ld.divisorIn = DB'(d);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    hist_clk = '0; hist_rise = '0; hist_fall = '0; hist_run = '0;
    m_run = 1'b0; adiv = DEF; pend = -1; idle_out();
`ifdef FREQDIV_PERIOD_COUNT_EN
    m_pc = 0;
`endif
    // reset wins over enable and load
    reset = 1'b1; enable = 1'b1; load(7);
    steps(3);
    reset = 1'b0; enable = 1'b0; ld.loadValid = 1'b0;
    step();

    // D=5 loaded together with enable
    load(5); enable = 1'b1;
    step();
    ld.loadValid = 1'b0;
    steps(9);
    chk("d5_clk",  {22'd0, hist_clk[9:0]},  {22'd0, 10'b1110011100});
    chk("d5_rise", {22'd0, hist_rise[9:0]}, {22'd0, 10'b1000010000});
    chk("d5_fall", {22'd0, hist_fall[9:0]}, {22'd0, 10'b0001000010});
    enable = 1'b0;
    steps(12);

    // D=4 running, load 6 at cnt=1
    load(4); enable = 1'b1;
    step();
    ld.loadValid = 1'b0;
    step();
    load(6);
    step();
    ld.loadValid = 1'b0;
    steps(11);
    chk("midrun_clk", {18'd0, hist_clk[13:0]}, {18'd0, 14'b11001110001110});
    steps(6);
    enable = 1'b0;
    steps(14);

    // D=8 running, load 3 then a refused attempt at 10
    load(8); enable = 1'b1;
    step();
    load(3);
    step();
    load(10);
    step();
    ld.loadValid = 1'b0;
    steps(20);
    enable = 1'b0;
    steps(10);

    // D=6, enable dropped at cnt=2
    load(6); enable = 1'b1;
    step();
    ld.loadValid = 1'b0;
    step();
    step();
    enable = 1'b0;
    steps(7);
    chk("stop_clk", {22'd0, hist_clk[9:0]}, {22'd0, 10'b1110000000});
    chk("stop_run", {22'd0, hist_run[9:0]}, {22'd0, 10'b1111110000});

    // divisor 0 clamps to 2
    load(0); enable = 1'b1;
    step();
    ld.loadValid = 1'b0;
    steps(9);
    chk("clamp_rise", {22'd0, hist_rise[9:0]}, {22'd0, 10'b1010101010});
    enable = 1'b0;
    steps(4);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      ld.loadValid = ($urandom_range(0, 7) == 0);
      ld.divisorIn = ($urandom_range(0, 3) == 0) ? DB'($urandom_range(0, 255))
                                                 : DB'($urandom_range(0, 9));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
